// File: rtl/muldiv_iter.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_DIVIDER_EN to build the divider; without it divide ops return 0 after FIX.
module muldiv_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            newOp,
    input  logic [XLEN-1:0] ia,
    input  logic [XLEN-1:0] ib,
    input  logic [3:0]      mulOp,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] mulOut,
    output logic [1:0]      dbg_state_o
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam int HW = XLEN / 2;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [3:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   out_q, out_d;

    logic              start, w_in, a_sgn, b_sgn, a_neg, b_neg, neg_in, special;
    logic [2:0]        f3_in;
    logic [XLEN-1:0]   a_ext, b_ext, a_abs, b_abs;
    logic [2*XLEN-1:0] load_acc, mul_next, step_acc, prod, fix_src, fix_val;
    logic [XLEN:0]     mul_hi;
    logic [XLEN-1:0]   fix_res;
`ifdef MULDIV_DIVIDER_EN
    logic              dz_q, dz_d, ovf_q, ovf_d, div_zero, div_ovf, rem_ge;
    logic [XLEN-1:0]   min_neg, rem_diff, div_sel;
    logic [XLEN:0]     rem_sh;
    logic [2*XLEN-1:0] div_next;
`endif

    assign start = en & newOp;

    // Operand decode at start: W forms narrow to 32 bits, then everything runs on magnitudes.
    always_comb begin
        w_in  = mulOp[3];
        f3_in = mulOp[2:0];
        a_sgn = (f3_in == 3'd1) || (f3_in == 3'd2) || (f3_in == 3'd4) || (f3_in == 3'd6);
        b_sgn = (f3_in == 3'd1) || (f3_in == 3'd4) || (f3_in == 3'd6);
        a_ext = w_in ? {{HW{a_sgn & ia[HW-1]}}, ia[HW-1:0]} : ia;
        b_ext = w_in ? {{HW{b_sgn & ib[HW-1]}}, ib[HW-1:0]} : ib;
        a_neg = a_sgn & a_ext[XLEN-1];
        b_neg = b_sgn & b_ext[XLEN-1];
        a_abs = a_neg ? -a_ext : a_ext;
        b_abs = b_neg ? -b_ext : b_ext;
        case (f3_in)
            3'd1, 3'd4: neg_in = a_neg ^ b_neg;
            3'd2, 3'd6: neg_in = a_neg;
            default:    neg_in = 1'b0;
        endcase
        load_acc = {{XLEN{1'b0}}, a_abs};
`ifdef MULDIV_DIVIDER_EN
        min_neg  = w_in ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (b_ext == '0);
        div_ovf  = b_sgn & (a_ext == min_neg) & (b_ext == '1);
        special  = f3_in[2] & (div_zero | div_ovf);
        // W dividends sit in the upper half so 32 iterations consume exactly their bits.
        if (f3_in[2] && w_in)
            load_acc = {{XLEN{1'b0}}, a_abs[HW-1:0], {HW{1'b0}}};
`else
        special  = f3_in[2];
`endif
    end

    // One iteration step and the FIX-stage result selection.
    always_comb begin
        mul_hi   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next = {mul_hi, acc_q[XLEN-1:1]};
        step_acc = mul_next;
        prod     = op_q[3] ? {{HW{1'b0}}, acc_q[2*XLEN-1:HW]} : acc_q;
        fix_src  = prod;
`ifdef MULDIV_DIVIDER_EN
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        rem_ge   = rem_sh >= {1'b0, b_q};
        rem_diff = rem_sh[XLEN-1:0] - b_q;
        div_next = {(rem_ge ? rem_diff : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], rem_ge};
        if (op_q[2])
            step_acc = div_next;
        div_sel  = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        if (op_q[2])
            fix_src = {{XLEN{1'b0}}, div_sel};
`endif
        fix_val = neg_q ? -fix_src : fix_src;
        fix_res = (op_q[2] || op_q[1:0] == 2'd0) ? fix_val[XLEN-1:0] : fix_val[2*XLEN-1:XLEN];
`ifdef MULDIV_DIVIDER_EN
        // Special cases carried the raw dividend in acc_q[XLEN-1:0].
        if (op_q[2] && dz_q)
            fix_res = op_q[1] ? acc_q[XLEN-1:0] : '1;
        else if (op_q[2] && ovf_q)
            fix_res = op_q[1] ? '0 : acc_q[XLEN-1:0];
`else
        if (op_q[2])
            fix_res = '0;
`endif
        if (op_q[3])
            fix_res = {{HW{fix_res[HW-1]}}, fix_res[HW-1:0]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        op_d    = op_q;
        neg_d   = neg_q;
        out_d   = out_q;
`ifdef MULDIV_DIVIDER_EN
        dz_d    = dz_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_d  = mulOp;
                    neg_d = neg_in;
                    b_d   = b_abs;
`ifdef MULDIV_DIVIDER_EN
                    dz_d  = div_zero;
                    ovf_d = div_ovf;
`endif
                    if (special) begin
                        state_d = S_FIX;
                        cnt_d   = '0;
                        acc_d   = {{XLEN{1'b0}}, a_ext};
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = w_in ? CW'(HW) : CW'(XLEN);
                        acc_d   = load_acc;
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (!en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_d == '0)
                        state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else begin
                    out_d   = fix_res;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            out_q   <= '0;
`ifdef MULDIV_DIVIDER_EN
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            out_q   <= out_d;
`ifdef MULDIV_DIVIDER_EN
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    // busy is combinational so execute stalls in the start cycle itself.
    assign busy = rst & ((start & (state_q == S_IDLE || state_q == S_DONE)) ||
                         state_q == S_RUN || state_q == S_FIX);
    assign done        = (state_q == S_DONE);
    assign mulOut      = out_q;
    assign dbg_state_o = state_q;
endmodule
